dmem_io_bridge: RTL

- Sits directly downstream of the pipelined processor's memory stage, between the processor's dmem port (address_dmem, data, wren, q_dmem) and the data RAM.
- Decodes each word address to one of three targets: the data RAM, a memory-mapped I/O register file, or an unmapped region.
- The I/O block contains an LED register, a free-running timer with a compare match, and a byte TX FIFO that drains to a UART over a valid/ready handshake.

---
 rtl/dmem_io_bridge.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dmem_io_bridge.sv
// dmem_io_bridge: address decoder between the processor dmem port and the data RAM.
// Maps the RAM, a small I/O block (LED, timer with compare, TX FIFO to the UART)
// and an unmapped region that reads as zero.
// Optional build macro DMEM_IO_SWITCH_EN adds a synchronized 16-bit switch input at IO offset 0x5.
module dmem_io_bridge #(
  parameter int RAM_AW   = 12,
  parameter int LED_W    = 8,
  parameter int TX_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       proc_addr,
  input  logic [31:0]       proc_wdata,
  input  logic              proc_wren,
  output logic [31:0]       proc_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_wren,
  input  logic [31:0]       ram_q,
  output logic [LED_W-1:0]  led,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              timer_match
`ifdef DMEM_IO_SWITCH_EN
  ,
  input  logic [15:0]       sw
`endif
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TX_DEPTH);

  logic              sel_ram, sel_io;
  logic [3:0]        io_off;
  logic              wr_led, wr_timer, wr_cmp, wr_status, wr_tx;

  logic [LED_W-1:0]  led_q, led_d;
  logic [31:0]       timer_q, timer_d;
  logic [31:0]       cmp_q, cmp_d;
  logic              match_q, match_d;
  logic              ovf_q, ovf_d;

  logic [7:0]        fifo_mem [TX_DEPTH];
  logic [PW-1:0]     rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              fifo_full, fifo_empty, push, pop, ovf_set;

  logic [31:0]       led_ext, io_rdata;

`ifdef DMEM_IO_SWITCH_EN
  logic [15:0]       sw_meta_q, sw_sync_q;

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end
`endif

  // Address decode and per-register write strobes; the IO window sits at the top 16 words.
  always_comb begin
    sel_ram   = (proc_addr >> RAM_AW) == 32'd0;
    sel_io    = proc_addr[31:4] == 28'hFFFFFFF;
    io_off    = proc_addr[3:0];
    wr_led    = proc_wren && sel_io && (io_off == 4'h0);
    wr_timer  = proc_wren && sel_io && (io_off == 4'h1);
    wr_cmp    = proc_wren && sel_io && (io_off == 4'h2);
    wr_status = proc_wren && sel_io && (io_off == 4'h3);
    wr_tx     = proc_wren && sel_io && (io_off == 4'h4);
  end

  assign ram_addr  = proc_addr[RAM_AW-1:0];
  assign ram_wdata = proc_wdata;
  assign ram_wren  = proc_wren && sel_ram;

  // FIFO control: a pop frees the slot, so a push while full is still accepted alongside it.
  always_comb begin
    fifo_full  = cnt_q == DEPTH_C;
    fifo_empty = cnt_q == '0;
    pop        = !fifo_empty && tx_ready;
    push       = wr_tx && (!fifo_full || pop);
    ovf_set    = wr_tx && fifo_full && !pop;
    rptr_d     = pop  ? rptr_q + PW'(1) : rptr_q;
    wptr_d     = push ? wptr_q + PW'(1) : wptr_q;
    cnt_d      = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  // Register next-state: timer write beats the increment, match set beats the STATUS clear.
  always_comb begin
    led_d   = wr_led ? proc_wdata[LED_W-1:0] : led_q;
    timer_d = wr_timer ? 32'd0 : timer_q + 32'd1;
    cmp_d   = wr_cmp ? proc_wdata : cmp_q;
    match_d = (timer_d == cmp_q) || (match_q && !wr_status);
    ovf_d   = ovf_set || (ovf_q && !wr_status);
  end

  // State registers for the I/O block and FIFO pointers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led_q   <= '0;
      timer_q <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      led_q   <= led_d;
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO storage is deliberately left unreset; tx_data masks it while empty.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wptr_q] <= proc_wdata[7:0];
  end

  assign led         = led_q;
  assign timer_match = match_q;
  assign tx_valid    = !fifo_empty;
  assign tx_data     = fifo_empty ? 8'h00 : fifo_mem[rptr_q];

  // Load data mux: RAM passthrough, IO register select, zero elsewhere.
  always_comb begin
    led_ext              = '0;
    led_ext[LED_W-1:0]   = led_q;
    io_rdata             = '0;
    case (io_off)
      4'h0: io_rdata = led_ext;
      4'h1: io_rdata = timer_q;
      4'h2: io_rdata = cmp_q;
      4'h3: io_rdata = {28'd0, ovf_q, match_q, fifo_empty, fifo_full};
`ifdef DMEM_IO_SWITCH_EN
      4'h5: io_rdata = {16'd0, sw_sync_q};
`endif
      default: io_rdata = '0;
    endcase
    if (sel_ram)     proc_rdata = ram_q;
    else if (sel_io) proc_rdata = io_rdata;
    else             proc_rdata = '0;
  end

endmodule
